// File: rtl/noc16_periph_ctrl_if.sv
// ---------------------------------------------------------------------------
// noc16_periph_ctrl_if
//   Request (Tx) and response (Rx) channels of the NOC16 peripheral service
//   port.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid and rdy are both 1. A source that raises valid keeps
//   valid and its data stable until that edge. rdy may be raised or lowered
//   freely; rdy while valid is 0 has no effect.
//
//   Signals:
//     Ksubs3_Noc16_TxData_lo/cmd/valid  requester -> controller
//     Ksubs3_Noc16_TxData_rdy           controller -> requester
//     Ksubs3_Noc16_RxData_lo/cmd/valid  controller -> consumer
//     Ksubs3_Noc16_RxData_rdy           consumer   -> controller
//
//   Modports: master = requester/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface noc16_periph_ctrl_if;
  logic [63:0] Ksubs3_Noc16_TxData_lo;
  logic [7:0]  Ksubs3_Noc16_TxData_cmd;
  logic        Ksubs3_Noc16_TxData_valid;
  logic        Ksubs3_Noc16_TxData_rdy;
  logic [63:0] Ksubs3_Noc16_RxData_lo;
  logic [7:0]  Ksubs3_Noc16_RxData_cmd;
  logic        Ksubs3_Noc16_RxData_valid;
  logic        Ksubs3_Noc16_RxData_rdy;

  modport master (
    output Ksubs3_Noc16_TxData_lo,
    output Ksubs3_Noc16_TxData_cmd,
    output Ksubs3_Noc16_TxData_valid,
    input  Ksubs3_Noc16_TxData_rdy,
    input  Ksubs3_Noc16_RxData_lo,
    input  Ksubs3_Noc16_RxData_cmd,
    input  Ksubs3_Noc16_RxData_valid,
    output Ksubs3_Noc16_RxData_rdy
  );

  modport slave (
    input  Ksubs3_Noc16_TxData_lo,
    input  Ksubs3_Noc16_TxData_cmd,
    input  Ksubs3_Noc16_TxData_valid,
    output Ksubs3_Noc16_TxData_rdy,
    output Ksubs3_Noc16_RxData_lo,
    output Ksubs3_Noc16_RxData_cmd,
    output Ksubs3_Noc16_RxData_valid,
    input  Ksubs3_Noc16_RxData_rdy
  );
endinterface

// File: rtl/noc16_periph_ctrl.sv
// ---------------------------------------------------------------------------
// noc16_periph_ctrl
//   Command controller for the NOC16 peripheral service port. Accepts one
//   request at a time, executes it against the peripheral register set and
//   returns exactly one response per request.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     bus (slave)           Tx request / Rx response channels
//     ksubsGpioSwitches     board switches, asynchronous to clk
//     ksubsGpioLeds         LED register
//     ksubsAbendSyndrome    sticky abend code
//     ksubsManualWaypoint   waypoint register
//     result_hi/result_lo   64-bit result register halves
//     req_count/err_count   saturating accepted / rejected request counters
//     dbg_state             FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
//   Each request takes IDLE (accept) -> EXEC (execute, register response and
//   side effects) -> RESP (hold response until consumed).
//   CNT_W must be between 1 and 16; counters are zero-extended to 16 bits in
//   the RD_STATUS word.
// ---------------------------------------------------------------------------
module noc16_periph_ctrl #(
  parameter logic [31:0] SERIAL_NUMBER = 32'd1236,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  noc16_periph_ctrl_if.slave bus,
  input  logic [7:0]       ksubsGpioSwitches,
  output logic [7:0]       ksubsGpioLeds,
  output logic [7:0]       ksubsAbendSyndrome,
  output logic [7:0]       ksubsManualWaypoint,
  output logic [31:0]      result_hi,
  output logic [31:0]      result_lo,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_RD_SERIAL   = 8'h01;
  localparam logic [7:0] OP_RD_SWITCH   = 8'h02;
  localparam logic [7:0] OP_WR_LEDS     = 8'h03;
  localparam logic [7:0] OP_WR_ABEND    = 8'h04;
  localparam logic [7:0] OP_WR_WAYPOINT = 8'h05;
  localparam logic [7:0] OP_WR_RESULT   = 8'h06;
  localparam logic [7:0] OP_ADD_RESULT  = 8'h07;
  localparam logic [7:0] OP_RD_STATUS   = 8'h08;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_next;

  logic        accept;
  logic [7:0]  cmd_q;
  logic [63:0] lo_q;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;

  logic [7:0]  leds;
  logic [7:0]  abend;
  logic [7:0]  waypoint;
  logic [63:0] result;
  logic [63:0] rx_lo;
  logic [7:0]  rx_cmd;

  // Execute-stage results, committed on the EXEC -> RESP edge.
  logic [7:0]  leds_next;
  logic [7:0]  abend_next;
  logic [7:0]  waypoint_next;
  logic [63:0] result_next;
  logic [63:0] exec_lo;
  logic [7:0]  exec_cmd;
  logic        exec_err;
  logic [15:0] req16;
  logic [15:0] err16;

  assign accept = (state == ST_IDLE) && bus.Ksubs3_Noc16_TxData_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.Ksubs3_Noc16_TxData_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (bus.Ksubs3_Noc16_RxData_rdy) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // rdy is masked by reset so the requester never sees it high while the
  // controller is being reset.
  always_comb begin
    bus.Ksubs3_Noc16_TxData_rdy   = (state == ST_IDLE) && !reset;
    bus.Ksubs3_Noc16_RxData_valid = (state == ST_RESP);
  end

  assign dbg_state = state;

  // ------------------------------------------------ switch synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= ksubsGpioSwitches;
      sw_sync <= sw_meta;
    end
  end

  // ------------------------------------------------------ decode/execute
  assign req16 = 16'(req_count);
  assign err16 = 16'(err_count);

  always_comb begin
    leds_next     = leds;
    abend_next    = abend;
    waypoint_next = waypoint;
    result_next   = result;
    exec_lo       = '0;
    exec_cmd      = {1'b1, cmd_q[6:0]};
    exec_err      = 1'b0;
    case (cmd_q)
      OP_NOP: exec_lo = '0;
      OP_RD_SERIAL: exec_lo = 64'(SERIAL_NUMBER);
      OP_RD_SWITCH: exec_lo = 64'(sw_sync);
      OP_WR_LEDS: begin
        leds_next = lo_q[7:0];
        exec_lo   = 64'(lo_q[7:0]);
      end
      OP_WR_ABEND: begin
        // Sticky: only a clear or a write into an empty syndrome lands;
        // anything else is silently dropped.
        if ((abend == 8'h00) || (lo_q[7:0] == 8'h00)) abend_next = lo_q[7:0];
        exec_lo = 64'(abend_next);
      end
      OP_WR_WAYPOINT: begin
        waypoint_next = lo_q[7:0];
        exec_lo       = 64'(lo_q[7:0]);
      end
      OP_WR_RESULT: begin
        result_next = lo_q;
        exec_lo     = lo_q;
      end
      OP_ADD_RESULT: begin
        result_next = result + lo_q;
        exec_lo     = result_next;
      end
      // req_count already includes this request (bumped at accept).
      OP_RD_STATUS: exec_lo = {16'h0000, req16, err16, 8'h00, abend};
      default: begin
        exec_err = 1'b1;
        exec_cmd = 8'hFF;
        exec_lo  = 64'(cmd_q);
      end
    endcase
  end

  // ----------------------------------------------------- datapath state
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= '0;
      lo_q      <= '0;
      req_count <= '0;
      err_count <= '0;
      leds      <= '0;
      abend     <= '0;
      waypoint  <= '0;
      result    <= '0;
      rx_lo     <= '0;
      rx_cmd    <= '0;
    end else begin
      if (accept) begin
        cmd_q <= bus.Ksubs3_Noc16_TxData_cmd;
        lo_q  <= bus.Ksubs3_Noc16_TxData_lo;
        if (req_count != CNT_MAX) req_count <= req_count + CNT_ONE;
      end
      if (state == ST_EXEC) begin
        leds     <= leds_next;
        abend    <= abend_next;
        waypoint <= waypoint_next;
        result   <= result_next;
        rx_lo    <= exec_lo;
        rx_cmd   <= exec_cmd;
        if (exec_err && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
      end
    end
  end

  assign bus.Ksubs3_Noc16_RxData_lo  = rx_lo;
  assign bus.Ksubs3_Noc16_RxData_cmd = rx_cmd;
  assign ksubsGpioLeds       = leds;
  assign ksubsAbendSyndrome  = abend;
  assign ksubsManualWaypoint = waypoint;
  assign result_hi           = result[63:32];
  assign result_lo           = result[31:0];

endmodule

// File: tb/tb_noc16_periph_ctrl.sv
// ---------------------------------------------------------------------------
// tb_noc16_periph_ctrl
//   Directed bench for noc16_periph_ctrl. Inputs are driven 1 time unit after
//   the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_noc16_periph_ctrl;

  // ------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ------------------------------------------------ DUT hookup
  logic [63:0] tx_lo = '0;
  logic [7:0]  tx_cmd = '0;
  logic        tx_valid = 1'b0;
  logic        rx_rdy = 1'b1;
  logic [7:0]  sw = '0;

  wire         tx_rdy;
  wire  [63:0] rx_lo;
  wire  [7:0]  rx_cmd;
  wire         rx_valid;

  logic [7:0]  leds, abend, waypoint;
  logic [31:0] res_hi, res_lo;
  logic [15:0] req_cnt, err_cnt;
  logic [1:0]  dbg_state;

  noc16_periph_ctrl_if bus ();

  assign bus.Ksubs3_Noc16_TxData_lo    = tx_lo;
  assign bus.Ksubs3_Noc16_TxData_cmd   = tx_cmd;
  assign bus.Ksubs3_Noc16_TxData_valid = tx_valid;
  assign bus.Ksubs3_Noc16_RxData_rdy   = rx_rdy;
  assign tx_rdy   = bus.Ksubs3_Noc16_TxData_rdy;
  assign rx_lo    = bus.Ksubs3_Noc16_RxData_lo;
  assign rx_cmd   = bus.Ksubs3_Noc16_RxData_cmd;
  assign rx_valid = bus.Ksubs3_Noc16_RxData_valid;

  noc16_periph_ctrl #(
    .SERIAL_NUMBER(32'd1236),
    .CNT_W(16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus.slave),
    .ksubsGpioSwitches   (sw),
    .ksubsGpioLeds       (leds),
    .ksubsAbendSyndrome  (abend),
    .ksubsManualWaypoint (waypoint),
    .result_hi           (res_hi),
    .result_lo           (res_lo),
    .req_count           (req_cnt),
    .err_count           (err_cnt),
    .dbg_state           (dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;

  // ------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for rdy, then present a request for exactly one edge.
  task automatic issue(input logic [7:0] c, input logic [63:0] l);
    int n = 0;
    while (tx_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_total++;
    if (tx_rdy !== 1'b1) $display("FAIL issue_rdy_timeout: tx_rdy=%b required 1", tx_rdy);
    else n_pass++;
    tx_cmd = c;
    tx_lo = l;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // lat counts edges from the accept cycle to the first cycle with rx_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (rx_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_total++;
    if (rx_valid !== 1'b1) $display("FAIL resp_timeout: rx_valid=%b required 1", rx_valid);
    else n_pass++;
  endtask

  // Full transaction with rx_rdy high; returns the response seen.
  task automatic do_req(input logic [7:0] c, input logic [63:0] l,
                        output logic [7:0] rc, output logic [63:0] rl, output int lat);
    issue(c, l);
    wait_resp(lat);
    rc = rx_cmd;
    rl = rx_lo;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    rx_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ------------------------------------------------ scenarios
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_total++;
    if ({tx_rdy, rx_valid} !== 2'b00)
      $display("FAIL reset_handshake: tx_rdy,rx_valid=%b required 00", {tx_rdy, rx_valid});
    else n_pass++;
    n_total++;
    if ({rx_lo, rx_cmd, leds, abend, waypoint, res_hi, res_lo, req_cnt, err_cnt} !== '0)
      $display("FAIL reset_outputs: lo=%h cmd=%h leds=%h abend=%h wp=%h res=%h%h req=%h err=%h required all 0",
               rx_lo, rx_cmd, leds, abend, waypoint, res_hi, res_lo, req_cnt, err_cnt);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (tx_rdy !== 1'b1) $display("FAIL reset_release_rdy: tx_rdy=%b required 1", tx_rdy);
    else n_pass++;
  endtask

  task automatic test_serial();
    logic [7:0] rc;
    logic [63:0] rl;
    int lat;
    do_req(8'h01, 64'h0, rc, rl, lat);
    n_total++;
    if (lat !== 2) $display("FAIL serial_latency: got %0d required 2", lat);
    else n_pass++;
    n_total++;
    if (rc !== 8'h81) $display("FAIL serial_cmd: got %h required 81", rc);
    else n_pass++;
    n_total++;
    if (rl !== 64'h4D4) $display("FAIL serial_lo: got %h required 4d4", rl);
    else n_pass++;
    n_total++;
    if (req_cnt !== 16'd1) $display("FAIL serial_req_count: got %0d required 1", req_cnt);
    else n_pass++;
  endtask

  task automatic test_switch_leds();
    logic [7:0] rc;
    logic [63:0] rl;
    int lat;
    sw = 8'hA5;
    tick();
    tick();
    tick();
    do_req(8'h02, 64'h0, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'h82, 64'hA5}) $display("FAIL rd_switch: cmd=%h lo=%h required 82/a5", rc, rl);
    else n_pass++;
    do_req(8'h03, 64'hFFFF_0000_0000_013C, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'h83, 64'h3C}) $display("FAIL wr_leds_resp: cmd=%h lo=%h required 83/3c", rc, rl);
    else n_pass++;
    n_total++;
    if (leds !== 8'h3C) $display("FAIL wr_leds_reg: got %h required 3c", leds);
    else n_pass++;
    do_req(8'h05, 64'h5A, rc, rl, lat);
    n_total++;
    if ({rc, rl, waypoint} !== {8'h85, 64'h5A, 8'h5A})
      $display("FAIL wr_waypoint: cmd=%h lo=%h wp=%h required 85/5a/5a", rc, rl, waypoint);
    else n_pass++;
    do_req(8'h00, 64'h1234, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'h80, 64'h0}) $display("FAIL nop: cmd=%h lo=%h required 80/0", rc, rl);
    else n_pass++;
  endtask

  task automatic test_abend();
    logic [7:0] rc;
    logic [63:0] rl;
    int lat;
    do_req(8'h04, 64'h12, rc, rl, lat);
    n_total++;
    if ({rc, rl, abend} !== {8'h84, 64'h12, 8'h12})
      $display("FAIL abend_first: cmd=%h lo=%h abend=%h required 84/12/12", rc, rl, abend);
    else n_pass++;
    do_req(8'h04, 64'h34, rc, rl, lat);
    n_total++;
    if ({rc, rl, abend} !== {8'h84, 64'h12, 8'h12})
      $display("FAIL abend_sticky: cmd=%h lo=%h abend=%h required 84/12/12", rc, rl, abend);
    else n_pass++;
    do_req(8'h04, 64'h0, rc, rl, lat);
    n_total++;
    if ({rl, abend} !== {64'h0, 8'h00}) $display("FAIL abend_clear: lo=%h abend=%h required 0/0", rl, abend);
    else n_pass++;
  endtask

  task automatic test_result();
    logic [7:0] rc;
    logic [63:0] rl;
    int lat;
    do_req(8'h06, 64'hFFFF_FFFF_FFFF_FFFF, rc, rl, lat);
    n_total++;
    if ({res_hi, res_lo, rl} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF})
      $display("FAIL wr_result: res=%h%h lo=%h required all ones", res_hi, res_lo, rl);
    else n_pass++;
    do_req(8'h07, 64'h2, rc, rl, lat);
    n_total++;
    if ({rc, res_hi, res_lo, rl} !== {8'h87, 32'h0, 32'h1, 64'h1})
      $display("FAIL add_result_wrap: cmd=%h res=%h_%h lo=%h required 87/0_1/1", rc, res_hi, res_lo, rl);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [7:0] rc;
    logic [63:0] rl;
    int lat;
    apply_reset();
    do_req(8'h09, 64'h0, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'hFF, 64'h09}) $display("FAIL err_09: cmd=%h lo=%h required ff/9", rc, rl);
    else n_pass++;
    do_req(8'h85, 64'h0, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'hFF, 64'h85}) $display("FAIL err_85: cmd=%h lo=%h required ff/85", rc, rl);
    else n_pass++;
    n_total++;
    if (err_cnt !== 16'd2) $display("FAIL err_count: got %0d required 2", err_cnt);
    else n_pass++;
    do_req(8'h08, 64'h0, rc, rl, lat);
    n_total++;
    if ({rc, rl} !== {8'h88, 64'h0000_0003_0002_0000})
      $display("FAIL rd_status: cmd=%h lo=%h required 88/0000000300020000", rc, rl);
    else n_pass++;
  endtask

  // Stall the response; a second request held on Tx must not be taken
  // until the first response is consumed.
  task automatic test_back_pressure();
    logic [7:0] c0, rc;
    logic [63:0] l0, rl;
    logic [15:0] req_before;
    int lat;
    rx_rdy = 1'b0;
    issue(8'h03, 64'h77);
    wait_resp(lat);
    c0 = rx_cmd;
    l0 = rx_lo;
    req_before = req_cnt;
    n_total++;
    if ({c0, l0} !== {8'h83, 64'h77}) $display("FAIL stall_resp: cmd=%h lo=%h required 83/77", c0, l0);
    else n_pass++;
    tx_cmd = 8'h03;
    tx_lo = 64'h11;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (rx_valid !== 1'b1 || rx_cmd !== c0 || rx_lo !== l0 || tx_rdy !== 1'b0 || req_cnt !== req_before)
        $display("FAIL stall_cycle%0d: valid=%b cmd=%h lo=%h tx_rdy=%b req=%0d required 1/%h/%h/0/%0d",
                 i, rx_valid, rx_cmd, rx_lo, tx_rdy, req_cnt, c0, l0, req_before);
      else n_pass++;
      tick();
    end
    rx_rdy = 1'b1;
    tick();
    n_total++;
    if ({rx_valid, tx_rdy} !== 2'b01) $display("FAIL stall_release: valid,tx_rdy=%b required 01", {rx_valid, tx_rdy});
    else n_pass++;
    tick();
    tx_valid = 1'b0;
    wait_resp(lat);
    rl = rx_lo;
    rc = rx_cmd;
    tick();
    n_total++;
    if ({rc, rl, leds, req_cnt} !== {8'h83, 64'h11, 8'h11, req_before + 16'd1})
      $display("FAIL held_request: cmd=%h lo=%h leds=%h req=%0d required 83/11/11/%0d",
               rc, rl, leds, req_cnt, req_before + 16'd1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    rx_rdy = 1'b0;
    issue(8'h06, 64'hDEAD_BEEF_CAFE_F00D);
    wait_resp(lat);
    n_total++;
    if ({res_hi, res_lo} !== 64'hDEAD_BEEF_CAFE_F00D)
      $display("FAIL mid_result_before: res=%h%h required deadbeefcafef00d", res_hi, res_lo);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if ({rx_valid, tx_rdy} !== 2'b00) $display("FAIL mid_reset_valid: valid,tx_rdy=%b required 00", {rx_valid, tx_rdy});
    else n_pass++;
    n_total++;
    if ({rx_lo, rx_cmd, leds, abend, waypoint, res_hi, res_lo, req_cnt, err_cnt} !== '0)
      $display("FAIL mid_reset_outputs: lo=%h cmd=%h leds=%h abend=%h wp=%h res=%h%h req=%h err=%h required all 0",
               rx_lo, rx_cmd, leds, abend, waypoint, res_hi, res_lo, req_cnt, err_cnt);
    else n_pass++;
    reset = 1'b0;
    rx_rdy = 1'b1;
    tick();
    n_total++;
    if ({rx_valid, tx_rdy} !== 2'b01) $display("FAIL mid_reset_recover: valid,tx_rdy=%b required 01", {rx_valid, tx_rdy});
    else n_pass++;
  endtask

  // ------------------------------------------------ sequence + report
  initial begin
    test_reset();
    test_serial();
    test_switch_leds();
    test_abend();
    test_result();
    test_errors();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/noc16_periph_ctrl.md
Name: noc16_periph_ctrl

Overview:
- Command controller for the NOC16 peripheral service port.
- Accepts one request at a time on the Tx channel (64-bit payload plus 8-bit command), decodes it, and executes it against the peripheral register set: LEDs, abend syndrome, manual waypoint, 64-bit result, serial number and switches.
- Returns exactly one response per request on the Rx channel.
- Sequences all peripheral register access so software on the NoC is the single owner of these registers.

Parameters:
- SERIAL_NUMBER, 32'd1236, value returned by RD_SERIAL.
- CNT_W, 16, width of the saturating request and error counters (must be ≤ 16).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Ksubs3_Noc16_TxData_lo  in  64  request payload
- Ksubs3_Noc16_TxData_cmd  in  8  request opcode
- Ksubs3_Noc16_TxData_valid  in  1  request valid
- Ksubs3_Noc16_TxData_rdy  out  1  controller can accept a request
- Ksubs3_Noc16_RxData_lo  out  64  response payload
- Ksubs3_Noc16_RxData_cmd  out  8  response code
- Ksubs3_Noc16_RxData_valid  out  1  response valid
- Ksubs3_Noc16_RxData_rdy  in  1  consumer accepts response
- ksubsGpioSwitches  in  8  board switches (asynchronous)
- ksubsGpioLeds  out  8  LED register
- ksubsAbendSyndrome  out  8  sticky abend code
- ksubsManualWaypoint  out  8  waypoint register
- result_hi  out  32  result register [63:32]
- result_lo  out  32  result register [31:0]
- req_count  out  CNT_W  accepted requests, saturating
- err_count  out  CNT_W  rejected requests, saturating

Behaviour:
- Reset values (registered, effective on the cycle after reset is sampled high):
  - All outputs 0; TxData_rdy 0 during reset.
  - FSM in IDLE; switch synchroniser 0.
- Switches pass through a 2-flop synchroniser. sw_sync is the second stage and is the only switch value visible to commands.
- FSM states:
  - IDLE: TxData_rdy=1. On TxData_valid=1, capture cmd and lo, increment req_count, go to EXEC.
  - EXEC: TxData_rdy=0. Perform the operation, register the response, go to RESP.
  - RESP: RxData_valid=1. RxData_lo and RxData_cmd are held stable until RxData_rdy=1, then go to IDLE.
- Timing: request accepted in cycle N → RxData_valid in cycle N+2. TxData_rdy rises the cycle after the response handshake. Peak throughput is one request per 3 cycles.
- Response code: {1'b1, cmd[6:0]} for a valid opcode; 8'hFF for an error.
- Opcodes (lo = captured payload; all responses zero-extended):
  - 0x00 NOP: response lo = 0.
  - 0x01 RD_SERIAL: response lo = SERIAL_NUMBER.
  - 0x02 RD_SWITCH: response lo = sw_sync, sampled in EXEC.
  - 0x03 WR_LEDS: leds <= lo[7:0]; response lo = new leds.
  - 0x04 WR_ABEND: sticky. Written only if current abend == 0, or if lo[7:0] == 0 (clear). Otherwise the write is ignored, with no error. Response lo = abend value after the cycle.
  - 0x05 WR_WAYPOINT: waypoint <= lo[7:0]; response lo = new waypoint.
  - 0x06 WR_RESULT: result <= lo; response lo = lo.
  - 0x07 ADD_RESULT: result <= result + lo, modulo 2^64 (carry dropped); response lo = new sum.
  - 0x08 RD_STATUS: response lo = {16'b0, req_count, err_count, 8'b0, abend}, with counters zero-extended to 16 bits.
  - Any other cmd, including any with bit 7 set: no register changes; increment err_count; response 8'hFF with lo = offending cmd.
- Register write timing: all register writes take effect at the end of EXEC. Outputs change in cycle N+2, together with RxData_valid.
- Counters: saturate at all-ones, never wrap. req_count counts every accepted request, including errors. RD_STATUS reports the counters after its own increment.
- Back-pressure:
  - TxData_valid while TxData_rdy=0 is not accepted; the requester must hold its request.
  - RxData_rdy held low stalls indefinitely in RESP with no data change.
  - RxData_rdy high while RxData_valid=0 is ignored.
- Reset mid-operation: a captured request or pending response is discarded and register side effects are reverted to reset values. RxData_valid is 0 the cycle after reset.

Test Plan:
- Reset, then RD_SERIAL with RxData_rdy=1 → RxData_valid exactly 2 cycles after accept; cmd=0x81, lo=0x4D4; req_count=1.
- Switches=0xA5, wait 3 cycles, RD_SWITCH → lo=0xA5. WR_LEDS lo=0x3C → ksubsGpioLeds=0x3C, response lo=0x3C.
- WR_ABEND 0x12, then WR_ABEND 0x34 → abend stays 0x12 and both responses carry 0x12. WR_ABEND 0x00 → abend 0x00.
- WR_RESULT 0xFFFFFFFF_FFFFFFFF, then ADD_RESULT 2 → result_hi=0, result_lo=1, response lo=1.
- cmd=0x09, then cmd=0x85 → responses 0xFF with lo=0x09 and lo=0x85; err_count=2. RD_STATUS → lo[31:16]=0x0002, lo[47:32]=0x0003.
- Hold RxData_rdy=0 for 10 cycles in RESP → valid, data and cmd stable and TxData_rdy=0 throughout. Assert reset during RESP → RxData_valid=0 next cycle and all outputs 0.
